// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display blocks.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // All anodes off (active-low)
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 3'b111;

  // Digit index encoding, ones digit is scanned first
  typedef enum logic [1:0] {
    ONES     = 2'd0,
    TENS     = 2'd1,
    HUNDREDS = 2'd2
  } digit_e;

  // Captured three-digit BCD payload
  typedef struct packed {
    logic [BCD_W-1:0] hundreds;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd3_t;

  // Active-low anode pattern selecting one digit, bit order {hundreds,tens,ones}
  function automatic logic [NUM_DIGITS-1:0] digit_anode(input digit_e d);
    logic [NUM_DIGITS-1:0] an;
    an = AN_OFF;
    case (d)
      ONES:     an = 3'b110;
      TENS:     an = 3'b101;
      HUNDREDS: an = 3'b011;
      default:  an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seven_seg_encode.sv
// seg7_encode: BCD digit to active-low 7-segment pattern; codes 10..15 blank.
module seg7_encode
  import seven_seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  // Pure lookup, no state
  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: captures three BCD digits and scans a 3-digit common-anode
// 7-segment display with one dead cycle at each digit switch.
// Optional leading-zero blanking: define SEVEN_SEG_LZB_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BCD_W-1:0]      hundreds,
  input  logic [BCD_W-1:0]      tens,
  input  logic [BCD_W-1:0]      ones,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]      cnt;
  digit_e                idx;
  digit_e                idx_next_c;
  bcd3_t                 cap;
  logic [BCD_W-1:0]      cur_bcd_c;
  logic [SEG_W-1:0]      enc_seg_c;
  logic                  blank_c;
  logic [SEG_W-1:0]      seg_next_c;
  logic [NUM_DIGITS-1:0] an_next_c;

  // Next digit in scan order ones -> tens -> hundreds -> ones
  always_comb begin
    idx_next_c = ONES;
    case (idx)
      ONES:     idx_next_c = TENS;
      TENS:     idx_next_c = HUNDREDS;
      HUNDREDS: idx_next_c = ONES;
      default:  idx_next_c = ONES;
    endcase
  end

  // Select the captured digit currently being scanned
  always_comb begin
    cur_bcd_c = cap.ones;
    case (idx)
      ONES:     cur_bcd_c = cap.ones;
      TENS:     cur_bcd_c = cap.tens;
      HUNDREDS: cur_bcd_c = cap.hundreds;
      default:  cur_bcd_c = cap.ones;
    endcase
  end

  seg7_encode u_encode (
    .bcd   (cur_bcd_c),
    .seg_c (enc_seg_c)
  );

`ifdef SEVEN_SEG_LZB_EN
  // Leading-zero blanking; ones is never blanked so 000 still shows "0"
  always_comb begin
    blank_c = 1'b0;
    case (idx)
      HUNDREDS: blank_c = (cap.hundreds == 4'd0);
      TENS:     blank_c = (cap.hundreds == 4'd0) && (cap.tens == 4'd0);
      default:  blank_c = 1'b0;
    endcase
  end
`else
  // Every digit is always encoded
  assign blank_c = 1'b0;
`endif

  // Output rule: dead time on cnt==0, otherwise light the current digit
  always_comb begin
    seg_next_c = SEG_BLANK;
    an_next_c  = AN_OFF;
    if (cnt != '0) begin
      an_next_c  = digit_anode(idx);
      seg_next_c = blank_c ? SEG_BLANK : enc_seg_c;
    end
  end

  // Captures, free-running prescaler/index and registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= ONES;
      cap <= '0;
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      if (load) begin
        cap <= '{hundreds: hundreds, tens: tens, ones: ones};
      end
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx_next_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      seg <= seg_next_c;
      an  <= an_next_c;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan with REFRESH_DIV=4.
// Honours SEVEN_SEG_LZB_EN the same way as the design.
module tb_seven_seg_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 3 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] hundreds = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic [6:0] seg;
  logic [2:0] an;

  int tests = 0;
  int fails = 0;

  // Reference model state: edges since reset (mod frame) and captured digits
  int         m_n = 0;
  logic [3:0] m_dig [3];  // [0]=ones [1]=tens [2]=hundreds
  logic [6:0] exp_seg;
  logic [2:0] exp_an;
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seven_seg_scan #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, expv);
    end
  endtask

  // Expected pins for one edge, from the slot position within the frame
  task automatic model_edge(input logic r, input logic l,
                            input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    int slot, d;
    logic [3:0] v;
    logic blank;
    if (r) begin
      exp_seg = 7'h7F;
      exp_an  = 3'b111;
      m_n = 0;
      m_dig[0] = 4'd0; m_dig[1] = 4'd0; m_dig[2] = 4'd0;
    end else begin
      slot = m_n % DIV;
      d    = m_n / DIV;
      if (slot == 0) begin
        exp_seg = 7'h7F;
        exp_an  = 3'b111;
      end else begin
        exp_an = 3'b111;
        exp_an[d] = 1'b0;
        v = m_dig[d];
        blank = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
        if (d == 2 && m_dig[2] == 4'd0) blank = 1'b1;
        if (d == 1 && m_dig[2] == 4'd0 && m_dig[1] == 4'd0) blank = 1'b1;
`endif
        exp_seg = (blank || v > 4'd9) ? 7'h7F : seg_tbl[v];
      end
      if (l) begin
        m_dig[0] = o; m_dig[1] = t; m_dig[2] = h;
      end
      m_n = (m_n + 1) % FRAME;
    end
  endtask

  // One clock: drive, let the edge happen, update the model, compare
  task automatic tick(input logic r, input logic l,
                      input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    rst = r; load = l; hundreds = h; tens = t; ones = o;
    @(posedge clk);
    model_edge(r, l, h, t, o);
    #1;
    check("seg", {1'b0, seg}, {1'b0, exp_seg});
    check("an", {5'd0, an}, {5'd0, exp_an});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  logic [2:0] an_seq [12] = '{3'b111, 3'b110, 3'b110, 3'b110,
                              3'b111, 3'b101, 3'b101, 3'b101,
                              3'b111, 3'b011, 3'b011, 3'b011};

  initial begin
    int guard;
    m_dig[0] = 4'd0; m_dig[1] = 4'd0; m_dig[2] = 4'd0;

    // Reset held for 3 cycles, then the first digit period after release
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    check("rel_dead", {5'd0, an}, 8'h07);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      check("rel_lit", {5'd0, an}, 8'h06);
    end

    // Re-align to frame start and load 255; anode pattern against a fixed table
    tick(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    tick(1'b0, 1'b1, 4'd2, 4'd5, 4'd5);
    check("an_seq", {5'd0, an}, {5'd0, an_seq[0]});
    for (int i = 1; i < 12; i++) begin
      tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      check("an_seq", {5'd0, an}, {5'd0, an_seq[i]});
    end
    idle(2);

    // Invalid tens code, then leading-zero cases
    tick(1'b0, 1'b1, 4'd1, 4'hA, 4'd3);  idle(FRAME + 1);
    tick(1'b0, 1'b1, 4'd0, 4'd0, 4'd7);  idle(FRAME + 1);
    tick(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);  idle(FRAME + 1);
    tick(1'b0, 1'b1, 4'd0, 4'd4, 4'd0);  idle(FRAME + 1);

    // Mid-scan 999 load inside the tens period
    guard = 0;
    while (!(m_n == DIV + 2) && guard < 2 * FRAME) begin
      idle(1); guard++;
    end
    check("align_tens", 8'(guard < 2 * FRAME), 8'd1);
    tick(1'b0, 1'b1, 4'd9, 4'd9, 4'd9);
    tick(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    check("midload_seg", {1'b0, seg}, 8'h10);
    check("midload_an", {5'd0, an}, 8'h05);

    // Reset in the middle of the hundreds period
    guard = 0;
    while (!(m_n == 2 * DIV + 2) && guard < 2 * FRAME) begin
      idle(1); guard++;
    end
    check("align_hund", 8'(guard < 2 * FRAME), 8'd1);
    tick(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    check("midrst_an", {5'd0, an}, 8'h07);
    idle(2);
    check("restart_ones", {5'd0, an}, 8'h06);

    // Random loads, digit values and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic r, l;
      logic [3:0] h, t, o;
      r = ($urandom_range(0, 79) == 0);
      l = ($urandom_range(0, 5) == 0);
      h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      o = 4'($urandom_range(0, 15));
      tick(r, l, h, t, o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Downstream consumer of the binary-to-BCD decoder: registers its three BCD digits (hundreds, tens, ones) on a load strobe and drives a 3-digit multiplexed common-anode 7-segment display. It time-multiplexes one digit at a time and inserts a one-cycle dead time at every digit switch to prevent ghosting. All outputs are registered and active-low, for direct connection to board pins.

## Interface
- REFRESH_DIV, default 50000: clock cycles per digit period. Minimum legal value is 2.
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- load  input  1  capture strobe. When high, the digit inputs are sampled at the clock edge.
- hundreds  input  4  BCD hundreds digit.
- tens  input  4  BCD tens digit.
- ones  input  4  BCD ones digit.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  output  3  anode enables {hundreds,tens,ones}, active-low.

## Operation
- Capture registers cap_h, cap_t and cap_o load hundreds, tens and ones on any edge where load=1.
- load held high makes the capture transparent (one-cycle delay).
- Prescaler cnt counts 0..REFRESH_DIV-1, then wraps to 0.
- Digit index idx advances on the wrap: 0 (ones) -> 1 (tens) -> 2 (hundreds) -> 0.
- Scanning is free-running. It is never restarted by load.
- Registered output rule, evaluated every edge:
  - if cnt==0: an<=3'b111 and seg<=7'h7F (dead time);
  - else: an<=~onehot(idx) and seg<=encode(cap[idx]).
- Segment encoding, active-low hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes 10..15 are invalid and encode as blank 7F. No error flag is raised.
- Reset values: seg=7'h7F, an=3'b111, cnt=0, idx=0, cap_h=cap_t=cap_o=0.
- Simultaneous rst and load: rst wins, and the captures clear.
- rst asserted mid-scan: all state returns to reset values at that edge.
- REFRESH_DIV=2: each digit period has 1 dead cycle and 1 lit cycle.

## Timing
- Load sampled at edge k: cap valid after edge k. seg reflects the new value from edge k+1, provided that digit is lit at k+1.
- First edge after rst deasserts (cnt=0): dead cycle, an=111. The next edge gives an=110.
- Digit period is exactly REFRESH_DIV cycles: 1 dead cycle plus REFRESH_DIV-1 lit cycles.
- Full scan frame is 3*REFRESH_DIV cycles.
- No combinational path from any input to any output.

## Configuration
- SEVEN_SEG_LZB_EN: leading-zero blanking, applied to the lit (non-dead) cycles.
- Defined:
  - hundreds digit is blanked (seg=7F) when cap_h==0;
  - tens digit is blanked when cap_h==0 and cap_t==0;
  - ones digit is never blanked, so 000 displays as "0";
  - the anode is still enabled for blanked digits, keeping brightness uniform.
- Undefined: all digits are always encoded, so 007 displays as "007".

## Structure
- Shared package seven_seg_pkg holds:
  - the segment constants SEG_0..SEG_9 and SEG_BLANK (7'h7F);
  - NUM_DIGITS=3;
  - the digit index encoding (ONES=0, TENS=1, HUNDREDS=2).
- One combinational sub-module, seg7_encode (4-bit BCD in, 7-bit active-low segments out). It is reused by future display blocks.
- The prescaler, index, captures, blanking logic and output registers live in seven_seg_scan.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: rst=1 for 3 cycles -> seg=7F, an=111 throughout. Release -> an=111 for 1 cycle, then 110 for 3 cycles.
- Load 2/5/5 (255) -> an repeats 111,110,110,110,111,101,101,101,111,011,011,011. seg is 12 for ones, 12 for tens, 24 for hundreds, and 7F on dead cycles.
- Load tens=4'hA, hundreds=1, ones=3 -> seg=7F during the tens lit cycles, 79 for hundreds, 30 for ones.
- Leading-zero blanking, load 0/0/7:
  - with SEVEN_SEG_LZB_EN: hundreds and tens lit cycles show seg=7F with their anode low, ones shows 78;
  - without the macro: 40,40,78;
  - load 0/0/0 with the macro: ones shows 40.
- Mid-scan load of 9/9/9 during the tens period -> tens seg changes to 10 on the following edge and the an sequence is undisturbed. Then rst for 1 cycle mid-hundreds period -> seg=7F, an=111, and the scan restarts at ones.
